// File: rtl/adc_temp_reader.sv
// -----------------------------------------------------------------------------
// adc_temp_reader
//
// Thermistor-channel front end for an external 12-bit SPI ADC. A free-running
// sample timer starts a 16-clock read frame every SAMPLE_DIV cycles while
// enable is high. Each frame is 4 leading zeros followed by D11..D0, MSB first.
// A frame whose top nibble is not zero is rejected. The latest good sample is
// held on temp.
//
// Parameters
//   CLK_DIV    : SCLK half-period in clk cycles (>= 2)
//   CS_SETUP   : clk cycles from CS fall to the first SCLK fall (>= 1)
//   SAMPLE_DIV : sample period in clk cycles (>= CS_SETUP + 32*CLK_DIV + 4)
//
// Ports
//   clk        in   system clock, all logic on posedge
//   rst        in   asynchronous active-high reset
//   enable     in   1 = periodic sampling runs, 0 = no new frames start
//   adc_miso   in   ADC serial data
//   adc_cs_n   out  ADC chip select, active low
//   adc_sclk   out  ADC serial clock, idles high
//   temp       out  last valid sample (raw unsigned ADC code)
//   temp_valid out  1-cycle pulse when temp is updated
//   frame_err  out  1-cycle pulse when a frame is rejected
// -----------------------------------------------------------------------------
module adc_temp_reader #(
  parameter int unsigned CLK_DIV    = 25,
  parameter int unsigned CS_SETUP   = 2,
  parameter int unsigned SAMPLE_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        adc_miso,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic [11:0] temp,
  output logic        temp_valid,
  output logic        frame_err
);

  // One counter serves both the CS setup delay and the SCLK half-periods.
  localparam int unsigned CntMax = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned TimerW = $clog2(SAMPLE_DIV);

  localparam logic [CntW-1:0]   SetupLast = CntW'(CS_SETUP - 1);
  localparam logic [CntW-1:0]   HalfLast  = CntW'(CLK_DIV - 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(SAMPLE_DIV - 1);
  localparam logic [4:0]        FrameBits = 5'd16;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StShift,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [15:0]       shift_q, shift_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic [11:0]       temp_q, temp_d;
  logic              temp_valid_q, temp_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              tick;

  // ---------------------------------------------------------------------------
  // Sample timer: held at zero while disabled, so the first tick after enable
  // rises lands a full SAMPLE_DIV period later.
  // ---------------------------------------------------------------------------
  assign tick = enable && (timer_q == TimerLast);

  always_comb begin
    timer_d = timer_q;
    if (!enable) begin
      timer_d = '0;
    end else if (timer_q == TimerLast) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame sequencer. All outputs are next-state registered, so nothing on the
  // output side depends combinationally on adc_miso.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    sclk_d       = sclk_q;
    cs_n_d       = cs_n_q;
    temp_d       = temp_q;
    temp_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Ticks seen outside idle are simply ignored.
        if (tick) begin
          state_d = StSetup;
          cnt_d   = '0;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b1;
        end
      end

      StSetup: begin
        if (cnt_q == SetupLast) begin
          state_d   = StShift;
          cnt_d     = '0;
          bit_cnt_d = '0;
          sclk_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StShift: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          if (!sclk_q) begin
            // End of low phase: SCLK rises and the ADC bit is captured.
            sclk_d    = 1'b1;
            shift_d   = {shift_q[14:0], adc_miso};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (bit_cnt_q == FrameBits) begin
            // End of the 16th high phase: close the frame and judge it.
            state_d = StDone;
            cs_n_d  = 1'b1;
            if (shift_q[15:12] == 4'h0) begin
              temp_d       = shift_q[11:0];
              temp_valid_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            sclk_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      sclk_q       <= 1'b1;
      cs_n_q       <= 1'b1;
      temp_q       <= '0;
      temp_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      sclk_q       <= sclk_d;
      cs_n_q       <= cs_n_d;
      temp_q       <= temp_d;
      temp_valid_q <= temp_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign adc_cs_n   = cs_n_q;
  assign adc_sclk   = sclk_q;
  assign temp       = temp_q;
  assign temp_valid = temp_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_adc_temp_reader.sv
// -----------------------------------------------------------------------------
// tb_adc_temp_reader
//
// Self-checking bench for adc_temp_reader. An ADC model serves one queued
// 16-bit word per chip-select frame and, at the same moment, the reference
// model pushes the expected outcome into a scoreboard. A monitor pops and
// compares on every temp_valid / frame_err pulse and also checks frame timing.
// -----------------------------------------------------------------------------
module tb_adc_temp_reader;

  localparam int unsigned CLK_DIV    = 2;
  localparam int unsigned CS_SETUP   = 2;
  localparam int unsigned SAMPLE_DIV = 200;
  localparam int unsigned FRAME_LOW  = CS_SETUP + 32 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        adc_miso;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic [11:0] temp;
  logic        temp_valid;
  logic        frame_err;

  adc_temp_reader #(
    .CLK_DIV   (CLK_DIV),
    .CS_SETUP  (CS_SETUP),
    .SAMPLE_DIV(SAMPLE_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .adc_miso  (adc_miso),
    .adc_cs_n  (adc_cs_n),
    .adc_sclk  (adc_sclk),
    .temp      (temp),
    .temp_valid(temp_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    logic [11:0] temp;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] word_q[$];
  int unsigned fall_cyc[$];

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  logic [11:0] model_temp = 12'h000;
  int          pulse_cnt = 0;
  int          err_cnt = 0;
  int          fall_cnt = 0;
  bit          in_frame = 1'b0;
  int          low_cnt = 0;
  int          rises = 0;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b1;
  logic [15:0] cur_word = 16'h0;
  int          bit_idx = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: a frame whose leading nibble is zero updates temp with its
  // low 12 bits; anything else is rejected and temp keeps the last good value.
  task automatic predict(input logic [15:0] w);
    exp_t e;
    if (w[15:12] == 4'h0) begin
      e.err      = 1'b0;
      e.temp     = w[11:0];
      model_temp = w[11:0];
    end else begin
      e.err  = 1'b1;
      e.temp = model_temp;
    end
    sb_q.push_back(e);
  endtask

  // ADC model: each frame takes the next queued word; a bit is presented on
  // every SCLK fall, MSB first.
  initial begin
    forever begin
      @(negedge adc_cs_n);
      if (word_q.size() == 0) begin
        check("unexpected_frame", 32'd1, 32'd0);
        cur_word = 16'hF000;
      end else begin
        cur_word = word_q.pop_front();
      end
      predict(cur_word);
      bit_idx = 15;
    end
  end

  initial begin
    forever begin
      @(negedge adc_sclk);
      if (adc_cs_n === 1'b0 && bit_idx >= 0) begin
        adc_miso = cur_word[bit_idx];
        bit_idx--;
      end
    end
  end

  initial begin
    forever begin
      @(posedge adc_cs_n);
      adc_miso = 1'b1;
    end
  end

  // Monitor: scoreboard compare on pulses plus per-frame timing checks.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame  = 1'b0;
        prev_cs   = 1'b1;
        prev_sclk = 1'b1;
      end else begin
        if (temp_valid && frame_err) check("pulse_exclusive", 32'd1, 32'd0);
        if (prev_cs && !adc_cs_n) begin
          in_frame = 1'b1;
          low_cnt  = 0;
          rises    = 0;
          fall_cnt++;
          fall_cyc.push_back(cyc);
        end
        if (!adc_cs_n) begin
          low_cnt++;
          if (!prev_sclk && adc_sclk) rises++;
        end
        if (!prev_cs && adc_cs_n && in_frame) begin
          check("cs_low_cycles", low_cnt, FRAME_LOW);
          check("sclk_rises", rises, 32'd16);
          check("pulse_at_cs_rise", {31'd0, temp_valid | frame_err}, 32'd1);
          in_frame = 1'b0;
        end
        if (temp_valid || frame_err) begin
          pulse_cnt++;
          if (frame_err) err_cnt++;
          if (sb_q.size() == 0) begin
            check("unexpected_pulse", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            check("pulse_kind_err", {31'd0, frame_err}, {31'd0, e.err});
            check("temp_value", {20'd0, temp}, {20'd0, e.temp});
          end
        end
        prev_cs   = adc_cs_n;
        prev_sclk = adc_sclk;
      end
    end
  end

  task automatic wait_pulse(input int n0);
    int t = 0;
    while (pulse_cnt == n0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    check("pulse_timeout", {31'd0, pulse_cnt != n0}, 32'd1);
  endtask

  task automatic run_frame(input logic [15:0] w);
    int n0 = pulse_cnt;
    word_q.push_back(w);
    wait_pulse(n0);
  endtask

  task automatic wait_rises(input int n);
    int t = 0;
    while (!(in_frame && rises >= n) && t < 1000) begin
      @(posedge clk);
      t++;
    end
    check("rise_wait_timeout", {31'd0, in_frame && rises >= n}, 32'd1);
  endtask

  task automatic check_spacing(input string name);
    int n = fall_cyc.size();
    if (n >= 2) check(name, fall_cyc[n-1] - fall_cyc[n-2], SAMPLE_DIV);
    else check({name, "_missing"}, n, 32'd2);
  endtask

  function automatic logic [15:0] rand_word();
    logic [3:0] hi;
    if ($urandom_range(3) == 0) hi = 4'($urandom_range(15, 1));
    else hi = 4'h0;
    return {hi, 12'($urandom)};
  endfunction

  initial begin
    int n0;
    int f0;
    int t;
    int e0;
    int unsigned c0;

    rst      = 1'b1;
    enable   = 1'b0;
    adc_miso = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cs_n", {31'd0, adc_cs_n}, 32'd1);
    check("reset_sclk", {31'd0, adc_sclk}, 32'd1);
    check("reset_temp", {20'd0, temp}, 32'd0);
    check("reset_temp_valid", {31'd0, temp_valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;

    // Basic frame.
    @(posedge clk);
    #1 enable = 1'b1;
    run_frame(16'h0ABC);
    check("temp_abc", {20'd0, temp}, 32'h0ABC);

    // Consecutive frames, full scale then zero.
    run_frame(16'h0FFF);
    check("temp_fff", {20'd0, temp}, 32'h0FFF);
    check_spacing("fall_spacing_fff");
    run_frame(16'h0000);
    check("temp_000", {20'd0, temp}, 32'h0000);
    check_spacing("fall_spacing_000");

    // Rejected frame after a good one.
    run_frame(16'h0555);
    e0 = err_cnt;
    run_frame(16'h8123);
    check("temp_held_after_err", {20'd0, temp}, 32'h0555);
    check("err_pulse_count", err_cnt - e0, 32'd1);

    // Reset in the middle of a frame.
    word_q.push_back(16'h0777);
    wait_rises(7);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_cs_n", {31'd0, adc_cs_n}, 32'd1);
    check("midrst_sclk", {31'd0, adc_sclk}, 32'd1);
    check("midrst_temp", {20'd0, temp}, 32'd0);
    check("midrst_temp_valid", {31'd0, temp_valid}, 32'd0);
    word_q.delete();
    sb_q.delete();
    model_temp = 12'h000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_frame(16'h0321);
    check("temp_after_reset", {20'd0, temp}, 32'h0321);

    // Enable drops mid-frame: frame completes, then silence.
    n0 = pulse_cnt;
    word_q.push_back(16'h0246);
    wait_rises(3);
    @(posedge clk);
    #1 enable = 1'b0;
    wait_pulse(n0);
    check("temp_after_disable", {20'd0, temp}, 32'h0246);
    f0 = fall_cnt;
    repeat (1000) @(posedge clk);
    check("no_frames_while_disabled", fall_cnt, f0);

    // Re-enable: the first frame starts one sample period later.
    n0 = pulse_cnt;
    word_q.push_back(rand_word());
    @(posedge clk);
    #1 enable = 1'b1;
    c0 = cyc;
    t  = 0;
    while (fall_cnt == f0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    check("reenable_frame_started", {31'd0, fall_cnt != f0}, 32'd1);
    if (fall_cnt != f0) check("reenable_delay", fall_cyc[fall_cyc.size()-1] - c0, SAMPLE_DIV);
    wait_pulse(n0);

    // Randomized back-to-back frames.
    for (int i = 0; i < 12; i++) begin
      run_frame(rand_word());
      check_spacing("fall_spacing_rand");
    end
    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/adc_temp_reader.md
# adc_temp_reader

Serial ADC front end for the thermistor channel. It periodically runs a 16-clock read frame on an external 12-bit SPI ADC (4 leading zeros, then D11..D0 MSB first), checks the frame, and presents the latest good sample on `temp`. `temp` feeds the heater control stage's `temp` input, which filters it and compares it against thresholds. The block owns sample timing, SCLK/CS generation and frame integrity checking.

## Interface
- CLK_DIV, 25: SCLK half-period in `clk` cycles (≥2); 50 MHz clk → 1 MHz SCLK.
- CS_SETUP, 2: `clk` cycles from CS fall to first SCLK fall (≥1).
- SAMPLE_DIV, 50000: sample period in `clk` cycles; must be ≥ CS_SETUP + 32·CLK_DIV + 4.

- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  1 = periodic sampling runs; 0 = no new frames start.
- adc_miso  in  1  ADC serial data.
- adc_cs_n  out  1  ADC chip select, active low.
- adc_sclk  out  1  ADC serial clock, idles high.
- temp  out  12  last valid sample, unsigned raw ADC code.
- temp_valid  out  1  1-cycle pulse when `temp` is updated.
- frame_err  out  1  1-cycle pulse when a frame is rejected.

## Operation
- Reset values: adc_cs_n=1, adc_sclk=1, temp=0, temp_valid=0, frame_err=0, state IDLE, timer=0, shift register=0.
- Sample timer: counts 0..SAMPLE_DIV-1 and wraps while `enable`=1. It is held at 0 while `enable`=0. The wrap cycle is the "tick".
- States: IDLE → SETUP → SHIFT → DONE → IDLE.
- IDLE: a tick moves to SETUP. A tick arriving outside IDLE is dropped; it is neither queued nor counted.
- SETUP: adc_cs_n=0, adc_sclk=1, held for CS_SETUP cycles, then SHIFT.
- SHIFT: 16 bit periods. Each period is sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - adc_miso is sampled into the shift register in the cycle adc_sclk goes 0→1.
  - Bit count increments on each rise. The state leaves after the 16th high phase.
- DONE (one cycle): adc_cs_n=1, adc_sclk=1.
  - If bits 15..12 of the frame are 0000: temp ← bits 11..0 and temp_valid=1.
  - Otherwise: frame_err=1 and temp holds its previous value.
- `enable` falling mid-frame: the current frame completes normally, including the temp update. No further frames start.
- Reset mid-frame: outputs return to reset values immediately (async). The partial frame is discarded.
- temp_valid and frame_err are never asserted in the same cycle.

## Timing
- Tick at cycle T → adc_cs_n=0 from T+1.
- First SCLK fall at T+1+CS_SETUP.
- adc_cs_n stays low for exactly CS_SETUP + 32·CLK_DIV cycles.
- DONE occurs at T+1+CS_SETUP+32·CLK_DIV. adc_cs_n=1 and the temp_valid/frame_err pulse occur in that same cycle, with temp updated in it.
- Frame start period equals SAMPLE_DIV cycles exactly while `enable`=1.
- After `enable` rises, the first tick comes SAMPLE_DIV cycles later.
- Data-to-`temp` latency: 1 cycle after the 16th SCLK rise + CLK_DIV high phase.
- All outputs are registered; no combinational path from adc_miso to any output.

## Test plan
Bench parameters: CLK_DIV=2, CS_SETUP=2, SAMPLE_DIV=200. The ADC model drives the next bit on each SCLK fall.
- Frame 0x0ABC, enable=1 → adc_cs_n low for 66 cycles, 16 SCLK rises, temp=0xABC with 1-cycle temp_valid coincident with adc_cs_n rise, frame_err=0.
- Consecutive frames 0x0FFF then 0x0000 → temp=0xFFF then 0x000. adc_cs_n falling edges exactly 200 cycles apart.
- Frame 0x8123 after a good 0x0555 → frame_err pulse, no temp_valid, temp stays 0x555.
- rst asserted after the 7th SCLK rise → adc_cs_n=1, adc_sclk=1, temp=0 immediately. After release with next frame 0x0321 → temp=0x321.
- enable dropped after the 3rd SCLK rise of frame 0x0246 → frame completes, temp=0x246. No further adc_cs_n activity for ≥1000 cycles. Re-enable → next frame starts 200 cycles later.
